// File: rtl/io_debounce_if.sv
// io_debounce_if: raw pin inputs, bypass control and debounced levels of the input-conditioning stage
interface io_debounce_if;
  logic [7:0] raw_switch;
  logic [4:0] raw_button;
  logic       bypass;
  logic [7:0] switch;
  logic [4:0] button;
  modport master (output raw_switch, raw_button, bypass, input switch, button);
  modport slave  (input raw_switch, raw_button, bypass, output switch, button);
endinterface

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchroniser plus per-bit tick-qualified debounce for 8 switches and 5 buttons
module io_debounce #(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input logic          clk,
  input logic          res_n,
  io_debounce_if.slave io
);
  localparam int N  = 13;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  logic [N-1:0]  s1, s2, q;
  logic [PW-1:0] pre;
  logic          tick;
  assign tick = pre == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      s1  <= '0;
      s2  <= '0;
      pre <= '0;
    end else begin
      s1  <= {io.raw_button, io.raw_switch};
      s2  <= s1;
      pre <= tick ? '0 : pre + 1'b1;
    end
  for (genvar i = 0; i < N; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          qb;
    logic          done;
    assign done = cnt == CW'(STABLE_TICKS - 1);
    // a bounce back to the held level (or bypass) restarts qualification
    always_ff @(posedge clk or negedge res_n)
      if (!res_n) begin
        cnt <= '0;
        qb  <= 1'b0;
      end else if (io.bypass || s2[i] == qb) begin
        cnt <= '0;
        qb  <= s2[i];
      end else if (tick) begin
        cnt <= done ? '0 : cnt + 1'b1;
        qb  <= done ? s2[i] : qb;
      end
    assign q[i] = qb;
  end
  assign io.switch = q[7:0];
  assign io.button = q[12:8];
endmodule

// File: tb/tb_io_debounce.sv
// tb_io_debounce: directed plan steps plus random toggling, checked against a run-length reference model
module tb_io_debounce;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int W  = (ST - 1) * TD + 1;
  logic clk = 1'b0;
  logic res_n = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [12:0] m_s1, m_s2, mq;
  int run[13];
  int e;
  io_debounce_if bus ();
  io_debounce #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (.clk(clk), .res_n(res_n), .io(bus));
  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {bus.button, bus.switch};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int d, input int lo, input int hi);
    n_tests++;
    assert (d >= lo && d <= hi) else begin
      n_fail++;
      $error("FAIL %s: latency %0d required %0d..%0d", tag, d, lo, hi);
    end
  endtask

  task automatic model_clear();
    mq = '0;
    m_s1 = '0;
    m_s2 = '0;
    e = 0;
    for (int i = 0; i < 13; i++) run[i] = 0;
  endtask

  // a bit flips at a tick edge once the synchronised level has opposed it, bypass off, for W edges
  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < 13; i++) begin
      if (bus.bypass) begin
        mq[i] = m_s2[i];
        run[i] = 0;
      end else if (m_s2[i] == mq[i]) run[i] = 0;
      else begin
        run[i]++;
        if (e % TD == TD - 1 && run[i] >= W) begin
          mq[i] = m_s2[i];
          run[i] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = {bus.raw_button, bus.raw_switch};
    e++;
    @(negedge clk);
    check("model", obs(), mq);
  endtask

  task automatic do_reset(input int n);
    res_n = 1'b0;
    model_clear();
    #1;
    check("rst_async", obs(), 0);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_hold", obs(), 0);
    end
    res_n = 1'b1;
  endtask

  task automatic wait_bit(input string tag, input int idx, input logic val, input int lo, input int hi);
    int d;
    logic [12:0] o;
    d = -1;
    for (int k = 0; k <= hi + 3 && d < 0; k++) begin
      cyc();
      o = obs();
      if (o[idx] === val) d = k;
    end
    check_rng(tag, d, lo, hi);
  endtask

  initial begin
    logic [12:0] o, r;
    logic prev;
    int ch;
    bus.bypass = 1'b0;
    bus.raw_switch = 8'hFF;
    bus.raw_button = 5'h1F;
    #2;
    do_reset(3);
    wait_bit("rst_release_lat", 0, 1'b1, 10, 13);
    check("rst_release_all", obs(), 13'h1FFF);

    bus.raw_switch = 8'h00;
    bus.raw_button = 5'h00;
    do_reset(2);
    repeat (5) cyc();
    bus.raw_button[2] = 1'b1;
    wait_bit("step_lat", 10, 1'b1, 10, 13);
    check("step_only", obs(), 13'h0400);

    for (int p = 0; p < 4; p++) begin
      bus.raw_switch[5] = (p % 2 == 0);
      repeat (3) cyc();
      o = obs();
      check("bounce_hold", o[5], 0);
    end
    bus.raw_switch[5] = 1'b1;
    wait_bit("bounce_lat", 5, 1'b1, 10, 13);
    ch = 0;
    prev = 1'b1;
    repeat (15) begin
      cyc();
      o = obs();
      if (o[5] !== prev) ch++;
      prev = o[5];
    end
    check("bounce_once", ch, 0);

    bus.raw_button[0] = 1'b1;
    repeat (6) cyc();
    bus.raw_button[0] = 1'b0;
    ch = 0;
    repeat (20) begin
      cyc();
      o = obs();
      if (o[8] !== 1'b0) ch++;
    end
    check("pulse_ignored", ch, 0);

    bus.raw_switch = 8'h00;
    repeat (20) cyc();
    check("byp_start", bus.switch, 8'h00);
    bus.bypass = 1'b1;
    bus.raw_switch = 8'hA5;
    cyc();
    cyc();
    check("byp_edge1", bus.switch, 8'h00);
    cyc();
    check("byp_edge2", bus.switch, 8'hA5);
    bus.bypass = 1'b0;
    bus.raw_switch = 8'h00;
    wait_bit("byp_exit_lat", 0, 1'b0, 10, 13);
    check("byp_exit_all", bus.switch, 8'h00);

    bus.raw_button = 5'h00;
    do_reset(2);
    bus.raw_switch[0] = 1'b1;
    repeat (8) cyc();
    o = obs();
    check("mid_pending", o[0], 0);
    do_reset(1);
    wait_bit("mid_rst_lat", 0, 1'b1, 10, 13);

    for (int k = 0; k < 600; k++) begin
      if (k == 300) do_reset(1);
      if ($urandom_range(3) == 0) begin
        r = {bus.raw_button, bus.raw_switch};
        r[$urandom_range(12)] ^= 1'b1;
        {bus.raw_button, bus.raw_switch} = r;
      end
      if ($urandom_range(49) == 0) begin
        bus.raw_switch = 8'($urandom);
        bus.raw_button = 5'($urandom);
      end
      if ($urandom_range(59) == 0) bus.bypass = ~bus.bypass;
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
